// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller feeding a combinational ALU: accepts instructions,
// reads operands from a 32-entry register file, drives the ALU and writes the result back.
module alu_issue_ctrl #(
    parameter int NREGS = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [31:0]   instr,
    input  logic          ld_en,
    input  logic [4:0]    ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [5:0]    alu_opcode,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    output logic          wb_valid,
    output logic [4:0]    wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          err,
    output logic          busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    localparam logic [5:0] OP_NOP = 6'h00;

    logic [1:0]    state_q, state_d;
    logic [5:0]    fetch_op_q;
    logic [4:0]    fetch_rd_q, rs1_q, rs2_q;
    logic [5:0]    op_q;
    logic [4:0]    rd_q;
    logic [DW-1:0] opa_q, opb_q;
    logic [DW-1:0] regs_q [NREGS];

    logic          hs;
    logic          ld_fire;
    logic          op_is_nop;
    logic          op_illegal;
    logic [DW-1:0] rs1_val, rs2_val;
    logic          unused_instr_bits;

    assign unused_instr_bits = ^instr[10:0];

    function automatic logic is_alu_op(input logic [5:0] op);
        case (op)
            6'h05, 6'h08, 6'h0D, 6'h07, 6'h03, 6'h06,
            6'h0A, 6'h02, 6'h0F, 6'h04, 6'h0C: is_alu_op = 1'b1;
            default:                           is_alu_op = 1'b0;
        endcase
    endfunction

    // A load in IDLE takes priority: ready drops so the offered instruction waits.
    assign instr_ready = (state_q == S_IDLE) && !ld_en;
    assign hs          = instr_valid && instr_ready;
    assign ld_fire     = (state_q == S_IDLE) && ld_en;

    assign op_is_nop   = (fetch_op_q == OP_NOP);
    assign op_illegal  = !op_is_nop && !is_alu_op(fetch_op_q);

    assign rs1_val = (rs1_q == 5'd0) ? '0 : regs_q[rs1_q];
    assign rs2_val = (rs2_q == 5'd0) ? '0 : regs_q[rs2_q];

    // NOTE: every output is assigned a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (hs) state_d = S_DECODE;
            S_DECODE: state_d = (op_illegal || op_is_nop) ? S_IDLE : S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign err        = (state_q == S_DECODE) && op_illegal;
    assign alu_opcode = ((state_q == S_EXEC) || (state_q == S_WB)) ? op_q : OP_NOP;
    assign alu_a      = opa_q;
    assign alu_b      = opb_q;
    assign wb_valid   = (state_q == S_WB);
    assign wb_addr    = (state_q == S_WB) ? rd_q : 5'd0;
    assign wb_data    = (state_q == S_WB) ? alu_result : '0;

    // NOTE: the register file is cleared by reset because a reset must leave every
    // register reading zero; this forces flops rather than a RAM macro.
    // NOTE: all state here uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_op_q <= '0;
            fetch_rd_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (hs) begin
                fetch_op_q <= instr[31:26];
                fetch_rd_q <= instr[25:21];
                rs1_q      <= instr[20:16];
                rs2_q      <= instr[15:11];
            end
            if (state_q == S_DECODE) begin
                op_q  <= fetch_op_q;
                rd_q  <= fetch_rd_q;
                opa_q <= rs1_val;
                opb_q <= rs2_val;
            end
            if (ld_fire && (ld_addr != 5'd0)) begin
                regs_q[ld_addr] <= ld_data;
            end
            // Operands were captured in DECODE, so rd == rs1/rs2 is safe here.
            if ((state_q == S_WB) && (rd_q != 5'd0)) begin
                regs_q[rd_q] <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a behavioural ALU model, a write-back/error
// scoreboard drained by a monitor, and cycle-accurate checks on the handshake timing.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          is_err;
        logic [4:0]  addr;
        logic [31:0] data;
        bit          chk_data;
    } exp_t;

    exp_t sb_q[$];

    alu_issue_ctrl #(.NREGS(32), .DW(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .err         (err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        logic signed [32:0] sum;
        sum = $signed({alu_a[31], alu_a}) + $signed({alu_b[31], alu_b});
        alu_result = 32'h0;
        case (alu_opcode)
            6'h05: alu_result = alu_a + alu_b;
            6'h08: alu_result = alu_a - alu_b;
            6'h0D: alu_result = alu_a[31] ? (32'h0 - alu_a) : alu_a;
            6'h07: alu_result = 32'h0 - alu_a;
            6'h03: alu_result = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
            6'h06: alu_result = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
            6'h0A: alu_result = sum[32:1];
            6'h02: alu_result = ~alu_a;
            6'h0F: alu_result = alu_a | alu_b;
            6'h04: alu_result = alu_a & alu_b;
            6'h0C: alu_result = alu_a ^ alu_b;
            default: alu_result = 32'h0;
        endcase
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        mk = {op, rd, rs1, rs2, 11'h0};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
        n_checks++;
        if (actual !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, actual, want);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic exp_wb(input logic [4:0] addr, input logic [31:0] data, input bit chk_data);
        exp_t e;
        e.is_err = 1'b0; e.addr = addr; e.data = data; e.chk_data = chk_data;
        sb_q.push_back(e);
    endtask

    task automatic exp_err();
        exp_t e;
        e.is_err = 1'b1; e.addr = 5'd0; e.data = 32'h0; e.chk_data = 1'b0;
        sb_q.push_back(e);
    endtask

    // Monitor: every write-back or error pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (wb_valid || err) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_event: wb_valid=%0b err=%0b wb_addr=%0d want no event",
                         wb_valid, err, wb_addr);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("event_is_err", {31'h0, err}, {31'h0, e.is_err});
                check("event_is_wb", {31'h0, wb_valid}, {31'h0, !e.is_err});
                if (!e.is_err) begin
                    check("wb_addr", {27'h0, wb_addr}, {27'h0, e.addr});
                    if (e.chk_data) check("wb_data", wb_data, e.data);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr_ready"}, {31'h0, instr_ready}, 32'h1);
        check({tag, "_busy"},        {31'h0, busy},        32'h0);
        check({tag, "_wb_valid"},    {31'h0, wb_valid},    32'h0);
        check({tag, "_err"},         {31'h0, err},         32'h0);
        check({tag, "_wb_addr"},     {27'h0, wb_addr},     32'h0);
        check({tag, "_wb_data"},     wb_data,              32'h0);
        check({tag, "_alu_opcode"},  {26'h0, alu_opcode},  32'h0);
        check({tag, "_alu_a"},       alu_a,                32'h0);
        check({tag, "_alu_b"},       alu_b,                32'h0);
    endtask

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic load(input logic [4:0] addr, input logic [31:0] data);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] word, input bit hold_valid);
        bit ok;
        ok = 1'b0;
        instr = word;
        instr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("issue_handshake");
        @(posedge clk); #1;
        if (!hold_valid) instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_ready && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_idle");
        @(posedge clk); #1;
    endtask

    initial begin
        int k;
        rst_n = 1'b0; instr_valid = 1'b0; instr = 32'h0;
        ld_en = 1'b0; ld_addr = 5'd0; ld_data = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic add with cycle-exact timing
        load(5'd1, 32'd7);
        load(5'd2, 32'd5);
        exp_wb(5'd3, 32'd12, 1'b1);
        issue(mk(6'h05, 5'd3, 5'd1, 5'd2), 1'b0);
        @(negedge clk);
        check("add_c1_busy", {31'h0, busy}, 32'h1);
        check("add_c1_ready", {31'h0, instr_ready}, 32'h0);
        check("add_c1_opcode", {26'h0, alu_opcode}, 32'h0);
        @(negedge clk);
        check("add_exec_opcode", {26'h0, alu_opcode}, 32'h05);
        check("add_exec_a", alu_a, 32'd7);
        check("add_exec_b", alu_b, 32'd5);
        @(negedge clk);
        check("add_c3_wb_valid", {31'h0, wb_valid}, 32'h1);
        @(negedge clk);
        check("add_c4_ready", {31'h0, instr_ready}, 32'h1);
        check("add_c4_opcode", {26'h0, alu_opcode}, 32'h0);
        @(posedge clk); #1;

        // Read r3 back through r3 | r0
        exp_wb(5'd11, 32'd12, 1'b1);
        issue(mk(6'h0F, 5'd11, 5'd3, 5'd0), 1'b0);
        wait_idle();

        // Back-to-back with read-after-write: r3 = r1 + r2, then r4 = r3 - r1
        exp_wb(5'd3, 32'd12, 1'b1);
        exp_wb(5'd4, 32'd5, 1'b1);
        issue(mk(6'h05, 5'd3, 5'd1, 5'd2), 1'b1);
        instr = mk(6'h08, 5'd4, 5'd3, 5'd1);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k++;
            if (instr_ready) break;
        end
        check("b2b_accept_cycle", k, 32'd4);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        wait_idle();

        // Illegal opcode: err in cycle 1, ready again in cycle 2
        exp_err();
        issue(mk(6'h01, 5'd5, 5'd1, 5'd2), 1'b0);
        @(negedge clk);
        check("illegal_c1_err", {31'h0, err}, 32'h1);
        @(negedge clk);
        check("illegal_c2_ready", {31'h0, instr_ready}, 32'h1);
        check("illegal_c2_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;

        // NOP: neither err nor write-back
        issue(mk(6'h00, 5'd6, 5'd1, 5'd2), 1'b0);
        @(negedge clk);
        check("nop_c1_err", {31'h0, err}, 32'h0);
        @(negedge clk);
        check("nop_c2_ready", {31'h0, instr_ready}, 32'h1);
        @(posedge clk); #1;

        // Write-back to r0 pulses but is discarded
        exp_wb(5'd0, 32'd0, 1'b0);
        issue(mk(6'h05, 5'd0, 5'd1, 5'd2), 1'b0);
        wait_idle();
        exp_wb(5'd12, 32'd0, 1'b1);
        issue(mk(6'h0F, 5'd12, 5'd0, 5'd0), 1'b0);
        wait_idle();

        // Load and handshake in the same IDLE cycle: load wins, instruction next cycle
        ld_en = 1'b1; ld_addr = 5'd7; ld_data = 32'h0000_1234;
        instr = mk(6'h0F, 5'd8, 5'd7, 5'd0);
        instr_valid = 1'b1;
        exp_wb(5'd8, 32'h0000_1234, 1'b1);
        @(negedge clk);
        check("ld_collide_ready", {31'h0, instr_ready}, 32'h0);
        @(posedge clk); #1;
        ld_en = 1'b0;
        @(negedge clk);
        check("ld_after_ready", {31'h0, instr_ready}, 32'h1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(negedge clk);
        check("ld_after_accepted", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        wait_idle();

        // Signed operands: abs, avg, max, and neg with rd == rs1
        load(5'd1, 32'hFFFF_FFF8);
        load(5'd2, 32'd4);
        exp_wb(5'd3, 32'd8, 1'b1);
        issue(mk(6'h0D, 5'd3, 5'd1, 5'd0), 1'b0);
        wait_idle();
        exp_wb(5'd4, 32'hFFFF_FFFE, 1'b1);
        issue(mk(6'h0A, 5'd4, 5'd1, 5'd2), 1'b0);
        wait_idle();
        exp_wb(5'd6, 32'd4, 1'b1);
        issue(mk(6'h03, 5'd6, 5'd1, 5'd2), 1'b0);
        wait_idle();
        exp_wb(5'd6, 32'hFFFF_FFFC, 1'b1);
        issue(mk(6'h07, 5'd6, 5'd6, 5'd0), 1'b0);
        wait_idle();
        exp_wb(5'd9, 32'hFFFF_FFFC, 1'b1);
        issue(mk(6'h0F, 5'd9, 5'd6, 5'd0), 1'b0);
        wait_idle();

        // Reset during EXEC aborts the instruction and clears the register file
        issue(mk(6'h05, 5'd10, 5'd1, 5'd2), 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_exec_opcode", {26'h0, alu_opcode}, 32'h05);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_wb(5'd10, 32'd0, 1'b1);
        issue(mk(6'h05, 5'd10, 5'd1, 5'd2), 1'b0);
        wait_idle();

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
